max_pool_stream: RTL and testbench
==================================

# max_pool_stream

Streaming 2x2, stride-2 max-pooling engine for signed N-bit feature-map pixels arriving in row-major raster order, one pixel per `ce` strobe. It sits after a convolution/activation stage. Each pooled result is formed as a running maximum, reset at window boundaries. A half-row line buffer holds the top-row partial maxima, and the block emits one pooled pixel per 2x2 window with a valid strobe and an end-of-frame marker.

## Interface
- `N`, 16: pixel width, signed two's complement.
- `W`, 28: input row width in pixels; even, ≥2.
- `H`, 28: input rows per frame; even, ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `master_rst`  in  1  reset, asynchronous and active-high; clears all control state and outputs.
- `ce`  in  1  input pixel valid; `din` accepted on every `clk` edge with `ce`=1.
- `rst_m`  in  1  synchronous frame restart: drops the partial frame and returns the counters to row 0, col 0.
- `din`  in  N  input pixel.
- `dout`  out  N  pooled pixel, registered.
- `valid_op`  out  1  one-cycle strobe; `dout` is valid.
- `end_op`  out  1  one-cycle strobe coincident with the last `valid_op` of a frame.

## Operation
- Counters: `col` runs 0..W-1 and `row` runs 0..H-1; both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - At `row`=H-1, `col`=W-1, both wrap to 0 and the next frame starts with no gap.
- Horizontal stage:
  - Even `col`: `hold` <= `din`.
  - Odd `col`: `pair` = signed max(`hold`, `din`), combinational.
- Vertical stage, on odd `col`:
  - Even `row`: `line_buf[col>>1]` <= `pair`. No output.
  - Odd `row`: `dout` <= signed max(`line_buf[col>>1]`, `pair`); `valid_op` <= 1.
- Line buffer: W/2 entries of N bits. It is not reset; every entry is written before it is read within a frame.
- Output count: W/2 outputs per odd row, (W/2)*(H/2) per frame, in raster order of windows.
- Compare rules:
  - Full N-bit signed compare; no saturation or width growth.
  - Ties yield the common value.
- `end_op` is 1 in the same cycle as the `valid_op` produced by pixel (H-1, W-1).
- `ce`=0: all state holds; `valid_op` and `end_op` are 0 next cycle; `dout` holds its last value.
- `rst_m`=1 (sampled at `clk`, regardless of `ce`):
  - Counters and `hold` go to 0; `valid_op` and `end_op` go to 0.
  - A simultaneous pixel is discarded.
  - `dout` holds.
- `master_rst` asserted at any time, including mid-frame: immediately `dout`=0, `valid_op`=0, `end_op`=0, counters=0, `hold`=0. The partial frame is lost.

## Timing
- Latency: `valid_op`/`dout` appear on the `clk` edge that accepts the bottom-right pixel of a window, i.e. visible the cycle after the `ce` cycle carrying it.
- Throughput: one pixel per cycle sustained; `ce` may be driven continuously or gapped arbitrarily.
- No back-pressure: the consumer must sample `dout` during every `valid_op`=1 cycle.
- Reset values: `dout`=0, `valid_op`=0, `end_op`=0.
- Precedence, highest first: `master_rst`, `rst_m`, `ce`.

## Configuration
- Macro `MAXPOOL_RELU_EN`.
- Defined: the registered output is clamped, `dout` <= 0 when the pooled max is negative; otherwise the max passes through. ReLU is fused into the pool.
- Undefined: `dout` is the raw signed max, negative values preserved.
- Timing, strobes and counters are identical in both builds.

## Test plan
All scenarios use W=4, H=4, N=16 unless stated.
- Basic pool, macro off, `ce` held high.
  - Stimulus, row 0: 1, 5, 2, 3. Row 1: 4, 0, -7, 9. Row 2: -1, -2, -3, -4. Row 3: -5, -6, -8, -7.
  - Required: `valid_op` pulses with `dout` = 5, 9, -1, -3; `end_op` only with -3; exactly 4 pulses.
- Same frame with `MAXPOOL_RELU_EN` defined -> `dout` = 5, 9, 0, 0 with identical strobe cycles.
- Gapped input: same frame with `ce` toggling 1,0,1,0 -> same four outputs; each `valid_op` follows the accepting edge of pixels (1,1), (1,3), (3,1), (3,3); `valid_op`=0 during `ce`=0 cycles.
- Back-to-back frames: two frames streamed with no gap, second frame all 0x7FFF -> 5, 9, -1, -3 then four 0x7FFF; two `end_op` pulses.
- Mid-frame restarts:
  - `rst_m`=1 with `ce`=1 after 6 pixels, then a full frame -> only the full frame's 4 outputs; the discarded pixel produces nothing.
  - `master_rst` pulsed asynchronously between edges mid-frame -> outputs zero immediately, then the next frame pools correctly.
- Ties and extremes, N=16:
  - Window {-32768, -32768, -32768, -32768} -> -32768 (macro off).
  - Window {7, 7, 7, 7} -> 7.

Source files
------------

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster pixel stream, one pixel per ce.
// Optional macro MAXPOOL_RELU_EN clamps negative pooled results to zero.
module max_pool_stream #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 28,
  parameter int unsigned H = 28
) (
  input  logic         clk,
  input  logic         master_rst,
  input  logic         ce,
  input  logic         rst_m,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         valid_op,
  output logic         end_op
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(H);
  localparam int unsigned HALF_W = W / 2;
  localparam int unsigned AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [N-1:0]  hold;
  logic [N-1:0]  line_buf [HALF_W];

  logic [AW-1:0] lb_idx;
  logic [N-1:0]  pair;
  logic [N-1:0]  top;
  logic [N-1:0]  pool_max;
  logic [N-1:0]  pool_out;
  logic          accept;
  logic          col_last;
  logic          row_last;

  assign accept   = ce && !rst_m;
  assign col_last = (col == CW'(W - 1));
  assign row_last = (row == RW'(H - 1));
  assign lb_idx   = AW'(col >> 1);
  assign top      = line_buf[lb_idx];

  // Horizontal pair max and vertical window max, both full-width signed compares.
  always_comb begin
    pair     = ($signed(din) > $signed(hold)) ? din : hold;
    pool_max = ($signed(pair) > $signed(top)) ? pair : top;
`ifdef MAXPOOL_RELU_EN
    pool_out = pool_max[N-1] ? '0 : pool_max;
`else
    pool_out = pool_max;
`endif
  end

  // Top-row partial maxima; every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!master_rst && accept && col[0] && !row[0]) begin
      line_buf[lb_idx] <= pair;
    end
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      col      <= '0;
      row      <= '0;
      hold     <= '0;
      dout     <= '0;
      valid_op <= 1'b0;
      end_op   <= 1'b0;
    end else begin
      valid_op <= 1'b0;
      end_op   <= 1'b0;
      if (rst_m) begin
        col  <= '0;
        row  <= '0;
        hold <= '0;
      end else if (ce) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) begin
          hold <= din;
        end else if (row[0]) begin
          dout     <= pool_out;
          valid_op <= 1'b1;
          end_op   <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream with W=4, H=4, N=16; expectations follow MAXPOOL_RELU_EN.
module tb_max_pool_stream;

  logic        clk = 1'b0;
  logic        master_rst;
  logic        ce;
  logic        rst_m;
  logic [15:0] din;
  logic [15:0] dout;
  logic        valid_op;
  logic        end_op;

  int checks   = 0;
  int failures = 0;
  int last_dout = 0;
  int frame_px [16];
  int frame_ex [4];

  max_pool_stream #(.N(16), .W(4), .H(4)) dut (
    .clk(clk), .master_rst(master_rst), .ce(ce), .rst_m(rst_m),
    .din(din), .dout(dout), .valid_op(valid_op), .end_op(end_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic observe(input string tag, input bit ev, input int ed, input bit ee);
    if (ev) last_dout = ed;
    check({tag, ".valid"}, int'(valid_op), int'(ev));
    check({tag, ".end"},   int'(end_op),   int'(ee));
    check({tag, ".dout"},  int'($signed(dout)), last_dout);
  endtask

  // Called at a negedge; the pixel is accepted on the next posedge and checked at the following negedge.
  task automatic push(input string tag, input int pix, input bit ev, input int ed, input bit ee);
    ce  = 1'b1;
    din = 16'(pix);
    @(negedge clk);
    observe(tag, ev, ed, ee);
  endtask

  task automatic idle(input string tag);
    ce = 1'b0;
    @(negedge clk);
    observe(tag, 1'b0, 0, 1'b0);
  endtask

  task automatic run_frame(input string tag, input bit gap);
    for (int i = 0; i < 16; i++) begin
      int r, c;
      bit ev;
      r  = i / 4;
      c  = i % 4;
      ev = (r % 2 == 1) && (c % 2 == 1);
      push($sformatf("%s.p%0d", tag, i), frame_px[i], ev,
           relu(frame_ex[(r / 2) * 2 + c / 2]), i == 15);
      if (gap) idle($sformatf("%s.g%0d", tag, i));
    end
  endtask

  task automatic load_basic();
    frame_px = '{1, 5, 2, 3,  4, 0, -7, 9,  -1, -2, -3, -4,  -5, -6, -8, -7};
    frame_ex = '{5, 9, -1, -3};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    master_rst = 1'b1;
    ce = 1'b0;
    rst_m = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    observe("reset", 1'b0, 0, 1'b0);
    master_rst = 1'b0;
    @(negedge clk);

    load_basic();
    run_frame("basic", 1'b0);
    idle("basic.after");

    run_frame("gapped", 1'b1);

    // Back-to-back frames, second saturated positive.
    run_frame("b2b0", 1'b0);
    frame_px = '{default: 32767};
    frame_ex = '{default: 32767};
    run_frame("b2b1", 1'b0);
    idle("b2b.after");

    // Partial frame then synchronous restart with a concurrent pixel that must be dropped.
    load_basic();
    for (int i = 0; i < 6; i++)
      push($sformatf("part.p%0d", i), frame_px[i], i == 5, relu(5), 1'b0);
    rst_m = 1'b1;
    ce    = 1'b1;
    din   = 16'(100);
    @(negedge clk);
    observe("rst_m", 1'b0, 0, 1'b0);
    rst_m = 1'b0;
    run_frame("after_rstm", 1'b0);
    idle("after_rstm.idle");

    // Asynchronous master reset between edges, mid-frame.
    push("amr.p0", 1, 1'b0, 0, 1'b0);
    push("amr.p1", 5, 1'b0, 0, 1'b0);
    ce = 1'b0;
    #2 master_rst = 1'b1;
    #1;
    last_dout = 0;
    observe("master_rst", 1'b0, 0, 1'b0);
    #1 master_rst = 1'b0;
    @(negedge clk);
    observe("master_rst.post", 1'b0, 0, 1'b0);
    run_frame("after_mrst", 1'b0);
    idle("after_mrst.idle");

    // Ties and extremes.
    frame_px = '{-32768, -32768, 7, 7,  -32768, -32768, 7, 7,  0, 0, -1, -1,  0, 0, -1, -1};
    frame_ex = '{-32768, 7, 0, -1};
    run_frame("ties", 1'b0);
    idle("ties.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
